// File: rtl/memory_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : memory_access_unit                                         |
// | Brief   : Pipeline memory stage. It issues word-aligned loads/stores |
// |           to the data memory with a bounded wait, and passes ALU and |
// |           call results through to writeback and forwarding.          |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module memory_access_unit #(
  parameter int DATA_W  = 32,
  parameter int RD_W    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  // execute stage
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [RD_W-1:0]   ex_rd,
  input  logic [DATA_W-1:0] ex_pc,
  input  logic              ex_is_ld,
  input  logic              ex_is_st,
  input  logic              ex_is_wb,
  input  logic              ex_is_call,
  output logic              mem_stall,
  // data memory
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  // writeback
  output logic              wb_valid,
  output logic              wb_we,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  // forwarding
  output logic              fw_valid,
  output logic [RD_W-1:0]   fw_rd,
  output logic [DATA_W-1:0] fw_result,
  // errors
  output logic              err_misaligned,
  output logic              err_timeout
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [0:0]       c_idle    = 1'b0;
  localparam logic [0:0]       c_access  = 1'b1;
  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(TIMEOUT - 1);

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
  logic [DATA_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_we_q, wb_we_d;
  logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              err_mis_q, err_mis_d;
  logic              err_to_q, err_to_d;

  logic w_is_mem;
  logic w_misaligned;

  assign w_is_mem     = ex_is_ld | ex_is_st;
  assign w_misaligned = (ex_alu_result[1:0] != 2'b00);

  // Next-state and next-output logic for the IDLE/ACCESS controller
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rd_d         = rd_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    wb_valid_d   = 1'b0;
    wb_we_d      = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    err_mis_d    = 1'b0;
    err_to_d     = 1'b0;

    case (state_q)
      c_idle: begin
        if (ex_valid) begin
          if (w_is_mem && w_misaligned) begin
            // Misaligned access retires without touching memory
            wb_valid_d = 1'b1;
            wb_rd_d    = ex_rd;
            wb_data_d  = '0;
            err_mis_d  = 1'b1;
          end else if (w_is_mem) begin
            // A simultaneous ld+st decodes as a load
            state_d      = c_access;
            cnt_d        = '0;
            rd_d         = ex_rd;
            dmem_req_d   = 1'b1;
            dmem_we_d    = ex_is_st & ~ex_is_ld;
            dmem_addr_d  = ex_alu_result;
            dmem_wdata_d = ex_store_data;
          end else begin
            wb_valid_d = 1'b1;
            wb_rd_d    = ex_rd;
            wb_we_d    = ex_is_wb;
            wb_data_d  = ex_is_call ? (ex_pc + DATA_W'(4)) : ex_alu_result;
          end
        end
      end
      default: begin
        // Ack is checked first so an ack on the last allowed cycle wins
        if (dmem_ack) begin
          state_d    = c_idle;
          dmem_req_d = 1'b0;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_we_d    = ~dmem_we_q;
          wb_data_d  = dmem_we_q ? '0 : dmem_rdata;
        end else if (cnt_q == c_cnt_max) begin
          state_d    = c_idle;
          dmem_req_d = 1'b0;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = '0;
          err_to_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  // State and registered outputs, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= c_idle;
      cnt_q        <= '0;
      rd_q         <= '0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      wb_valid_q   <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      err_mis_q    <= 1'b0;
      err_to_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_q         <= rd_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      wb_valid_q   <= wb_valid_d;
      wb_we_q      <= wb_we_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      err_mis_q    <= err_mis_d;
      err_to_q     <= err_to_d;
    end
  end

  // Stall is combinational so execute holds in the very cycle ack is absent
  assign mem_stall = (state_q == c_access) & ~dmem_ack;

  assign dmem_req       = dmem_req_q;
  assign dmem_we        = dmem_we_q;
  assign dmem_addr      = dmem_addr_q;
  assign dmem_wdata     = dmem_wdata_q;
  assign wb_valid       = wb_valid_q;
  assign wb_we          = wb_we_q;
  assign wb_rd          = wb_rd_q;
  assign wb_data        = wb_data_q;
  assign err_misaligned = err_mis_q;
  assign err_timeout    = err_to_q;

  assign fw_valid  = wb_valid_q & wb_we_q;
  assign fw_rd     = wb_rd_q;
  assign fw_result = wb_data_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_memory_access_unit                                      |
// | Brief   : Directed self-checking bench for memory_access_unit.       |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_memory_access_unit;

  localparam int DATA_W = 32;
  localparam int RD_W   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_alu_result;
  logic [DATA_W-1:0] ex_store_data;
  logic [RD_W-1:0]   ex_rd;
  logic [DATA_W-1:0] ex_pc;
  logic              ex_is_ld, ex_is_st, ex_is_wb, ex_is_call;
  logic              mem_stall;
  logic              dmem_req, dmem_we, dmem_ack;
  logic [DATA_W-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic              wb_valid, wb_we;
  logic [RD_W-1:0]   wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              fw_valid;
  logic [RD_W-1:0]   fw_rd;
  logic [DATA_W-1:0] fw_result;
  logic              err_misaligned, err_timeout;

  int n_checks = 0;
  int n_errors = 0;
  int req_cyc, stall_cyc;

  memory_access_unit #(.DATA_W(DATA_W), .RD_W(RD_W), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_pc(ex_pc), .ex_is_ld(ex_is_ld), .ex_is_st(ex_is_st),
    .ex_is_wb(ex_is_wb), .ex_is_call(ex_is_call), .mem_stall(mem_stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .fw_valid(fw_valid), .fw_rd(fw_rd), .fw_result(fw_result),
    .err_misaligned(err_misaligned), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid = 0; ex_is_ld = 0; ex_is_st = 0; ex_is_wb = 0; ex_is_call = 0;
  endtask

  task automatic issue(input logic ld, input logic st, input logic [DATA_W-1:0] addr,
                       input logic [DATA_W-1:0] wdata, input logic [RD_W-1:0] rd);
    ex_valid = 1; ex_is_ld = ld; ex_is_st = st; ex_alu_result = addr;
    ex_store_data = wdata; ex_rd = rd;
    tick();
    clear_ex();
  endtask

  // Runs the access in progress: ack on req cycle ack_at (0 = never)
  task automatic mem_txn(input int ack_at, input logic [DATA_W-1:0] rdata);
    req_cyc = 0;
    stall_cyc = 0;
    for (int i = 0; i < 40; i++) begin
      if (!dmem_req) break;
      req_cyc++;
      dmem_ack   = (req_cyc == ack_at);
      dmem_rdata = rdata;
      #1;
      if (mem_stall) stall_cyc++;
      tick();
      dmem_ack = 0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; clear_ex();
    ex_alu_result = 0; ex_store_data = 0; ex_rd = 0; ex_pc = 0;
    dmem_ack = 0; dmem_rdata = 0;
    tick(); tick();
    check("rst_wb_valid", wb_valid, 0);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_dmem_addr", dmem_addr, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_errs", {err_misaligned, err_timeout}, 0);
    check("rst_stall", mem_stall, 0);
    rst = 0;

    // ALU op
    ex_valid = 1; ex_alu_result = 32'h1234; ex_rd = 3; ex_is_wb = 1;
    tick(); clear_ex();
    check("alu_wb_valid", wb_valid, 1);
    check("alu_wb_rd", wb_rd, 3);
    check("alu_wb_data", wb_data, 32'h1234);
    check("alu_fw", {fw_valid, fw_rd, fw_result}, {1'b1, 4'd3, 32'h1234});
    tick();
    check("alu_pulse", {wb_valid, fw_valid}, 0);

    // Call: pc+4 wraps modulo 2^32
    ex_valid = 1; ex_is_call = 1; ex_is_wb = 1; ex_pc = 32'hFFFF_FFFE;
    ex_alu_result = 32'hDEAD; ex_rd = 1;
    tick(); clear_ex();
    check("call_wb", {wb_valid, wb_we, wb_rd, wb_data}, {1'b1, 1'b1, 4'd1, 32'h2});

    // Non-writing op
    ex_valid = 1; ex_alu_result = 32'h9; ex_rd = 2;
    tick(); clear_ex();
    check("nowb", {wb_valid, wb_we, fw_valid}, {1'b1, 1'b0, 1'b0});

    // Load 0x100, ack on 3rd request cycle
    issue(1, 0, 32'h100, 32'h0, 5);
    check("ld_req", {dmem_req, dmem_we, dmem_addr}, {1'b1, 1'b0, 32'h100});
    check("ld_wb_idle", wb_valid, 0);
    mem_txn(3, 32'hCAFE);
    check("ld_req_cycles", req_cyc, 3);
    check("ld_stall_cycles", stall_cyc, 2);
    check("ld_wb", {wb_valid, wb_we, wb_rd, wb_data}, {1'b1, 1'b1, 4'd5, 32'hCAFE});
    check("ld_fw_valid", fw_valid, 1);
    tick();
    check("ld_wb_pulse", wb_valid, 0);

    // Store 0x20 data 0x55, ack on 1st cycle
    issue(0, 1, 32'h20, 32'h55, 7);
    check("st_req", {dmem_req, dmem_we, dmem_addr, dmem_wdata}, {1'b1, 1'b1, 32'h20, 32'h55});
    mem_txn(1, 32'h1111);
    check("st_req_cycles", req_cyc, 1);
    check("st_stall_cycles", stall_cyc, 0);
    check("st_wb", {wb_valid, wb_we, wb_rd, fw_valid}, {1'b1, 1'b0, 4'd7, 1'b0});

    // ld and st both set behaves as a load
    issue(1, 1, 32'h40, 32'hAA, 9);
    check("ldst_we", dmem_we, 0);
    mem_txn(2, 32'h77);
    check("ldst_wb", {wb_valid, wb_we, wb_rd, wb_data}, {1'b1, 1'b1, 4'd9, 32'h77});

    // Misaligned load
    issue(1, 0, 32'h102, 32'h0, 4);
    check("mis_err", err_misaligned, 1);
    check("mis_req", dmem_req, 0);
    check("mis_wb", {wb_valid, wb_we, fw_valid}, {1'b1, 1'b0, 1'b0});
    check("mis_stall", mem_stall, 0);
    tick();
    check("mis_pulse", {err_misaligned, wb_valid, dmem_req}, 0);

    // Timeout: no ack
    issue(1, 0, 32'h200, 32'h0, 6);
    mem_txn(0, 32'h0);
    check("to_req_cycles", req_cyc, 16);
    check("to_stall_cycles", stall_cyc, 16);
    check("to_err", {err_timeout, err_misaligned}, {1'b1, 1'b0});
    check("to_wb", {wb_valid, wb_we, dmem_req}, {1'b1, 1'b0, 1'b0});
    tick();
    check("to_pulse", {err_timeout, wb_valid}, 0);

    // Ack on the 16th cycle wins over timeout
    issue(1, 0, 32'h204, 32'h0, 8);
    mem_txn(16, 32'hBEEF);
    check("late_req_cycles", req_cyc, 16);
    check("late_stall_cycles", stall_cyc, 15);
    check("late_err", err_timeout, 0);
    check("late_wb", {wb_valid, wb_we, wb_rd, wb_data}, {1'b1, 1'b1, 4'd8, 32'hBEEF});

    // Ack while idle is ignored
    dmem_ack = 1; dmem_rdata = 32'h5;
    tick();
    check("idle_ack", {wb_valid, dmem_req, mem_stall, err_timeout}, 0);
    dmem_ack = 0;

    // Reset on 2nd ACCESS cycle
    issue(1, 0, 32'h300, 32'h0, 2);
    tick();
    check("rst_acc_req", dmem_req, 1);
    rst = 1;
    tick();
    rst = 0;
    check("rst_acc_out", {dmem_req, wb_valid, err_timeout, err_misaligned}, 0);
    check("rst_acc_stall", mem_stall, 0);
    // Back in IDLE: a fresh ALU op must be accepted
    ex_valid = 1; ex_alu_result = 32'h42; ex_rd = 11; ex_is_wb = 1;
    tick(); clear_ex();
    check("rst_acc_idle", {wb_valid, wb_rd, wb_data}, {1'b1, 4'd11, 32'h42});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
